seed_random_4_card_requester: RTL and testbench
===============================================

SEED_RANDOM_4_CARD_REQUESTER -- requirements
Module: seed_random_4_card_requester

Interface
REQ-001 clk_dp_c_i  input  1  system clock; all state updates on its rising edge.
REQ-002 rst_dp_c_i  input  1  reset, asynchronous, active-low; clock clk_dp_c_i.
REQ-003 deal_req_i  input  1  game-controller request for one card; sampled only in IDLE.
REQ-004 shuffle_i  input  1  clears dealt-card tracking; sampled every cycle.
REQ-005 next_card_i  input  8  card index from the deck counter; 0 is invalid, 1..52 are cards.
REQ-006 req_card_state_o  output  1  drives the deck counter's advance input; each high cycle advances the counter by one.
REQ-007 card_valid_o  output  1  one-cycle pulse marking the decoded card outputs valid.
REQ-008 card_index_o  output  8  accepted card index, 1..52.
REQ-009 card_rank_o  output  4  rank 1..13.
REQ-010 card_suit_o  output  2  suit 0..3.
REQ-011 card_value_o  output  5  blackjack value: 2..11.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 deck_empty_o  output  1  all 52 cards have been dealt since the last reset or shuffle.
REQ-014 cards_dealt_o  output  6  number of accepted cards, 0..52.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, CHECK and DONE, registered and one-hot or binary.
- IDLE: if deal_req_i=1 and deck_empty_o=0, go to REQ next cycle; otherwise stay in IDLE.
- REQ: req_card_state_o=1 for exactly this one cycle; next state is CHECK.
- CHECK: sample next_card_i.
  - Index 0, index >52, or an already-dealt card (when the filter is enabled) is rejected; go to REQ (retry).
  - Otherwise accept; go to DONE.
- DONE: card_valid_o=1 for this one cycle; next state is IDLE.
REQ-016 req_card_state_o SHALL be 0 in IDLE, CHECK and DONE.
REQ-017 Latency SHALL be exactly 3 cycles on the accept path: deal_req_i seen in IDLE in cycle N, REQ in N+1, CHECK in N+2, card_valid_o=1 in N+3.
REQ-018 Each rejection SHALL add exactly 2 cycles (REQ + CHECK).
REQ-019 On accept, the block SHALL register the card outputs, effective in DONE, and hold them until the next accept:
- card_index_o = k
- card_suit_o = (k-1)/13
- card_rank_o = ((k-1) mod 13)+1
- card_value_o: 11 for rank 1, the rank for ranks 2..10, 10 for ranks 11..13.
REQ-020 On accept, cards_dealt_o SHALL increment by 1 and saturate at 52.
REQ-021 deck_empty_o SHALL be registered high when cards_dealt_o reaches 52.
REQ-022 deal_req_i SHALL be ignored outside IDLE; it is not queued.
REQ-023 When deck_empty_o=1, deal_req_i SHALL be ignored and req_card_state_o SHALL stay 0.
REQ-024 shuffle_i=1 SHALL clear cards_dealt_o, the dealt mask and deck_empty_o on the next edge.
- The FSM state is unaffected.
- If shuffle_i coincides with an accept, the clear wins and cards_dealt_o becomes 0.
REQ-025 Wrap of the deck counter from 52 to 0 SHALL be handled as an ordinary rejection of index 0.

Reset
REQ-026 Asserting rst_dp_c_i low, at any time including mid-transaction, SHALL immediately set:
- FSM = IDLE
- req_card_state_o = 0, card_valid_o = 0, busy_o = 0
- card_index_o, card_rank_o, card_suit_o, card_value_o = 0
- cards_dealt_o = 0, deck_empty_o = 0
- dealt mask all 0.
REQ-027 The first deal_req_i SHALL be accepted in the first cycle after rst_dp_c_i deasserts.

Configuration
REQ-028 Macro SEED_RANDOM_4_DUP_FILTER_EN SHALL select duplicate filtering.
- Defined: a 52-bit dealt mask is kept; CHECK rejects an index whose mask bit is set; the bit is set on accept.
- Undefined: no mask is implemented; only indices 0 and >52 are rejected; cards_dealt_o and deck_empty_o behave as in REQ-020, REQ-021 and REQ-023.

Verification
REQ-029 Reset, counter at 0, deal_req_i pulse -> req_card_state_o high 1 cycle, card_valid_o in cycle N+3; index 1, rank 1, suit 0, value 11; cards_dealt_o=1.
REQ-030 13 consecutive deals after reset -> 13th card is index 13, rank 13, suit 0, value 10; 10th card is value 10, rank 10.
REQ-031 52 deals with filter enabled -> deck_empty_o=1, cards_dealt_o=52; 53rd deal_req_i -> no req_card_state_o pulse, busy_o stays 0.
REQ-032 Then shuffle_i pulse, then deal -> CHECK sees 0 (wrap), retry, accept index 1; card_valid_o at N+5; cards_dealt_o=1.
REQ-033 Bench forces next_card_i to an already-dealt index 5 in the first CHECK, then 6 -> one retry; card_index_o=6 with filter, card_index_o=5 without.
REQ-034 rst_dp_c_i low during CHECK -> all outputs 0 immediately; deal after release -> normal 3-cycle accept.

Source files
------------

// File: rtl/seed_random_4_card_requester_if.sv
// Request/card-output bundle between the game controller, the deck counter and the card requester.
interface seed_random_4_card_requester_if;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned RANK_W  = 4;
  localparam int unsigned SUIT_W  = 2;
  localparam int unsigned VALUE_W = 5;
  localparam int unsigned CNT_W   = 6;

  logic               deal_req_i;
  logic               shuffle_i;
  logic [IDX_W-1:0]   next_card_i;
  logic               req_card_state_o;
  logic               card_valid_o;
  logic [IDX_W-1:0]   card_index_o;
  logic [RANK_W-1:0]  card_rank_o;
  logic [SUIT_W-1:0]  card_suit_o;
  logic [VALUE_W-1:0] card_value_o;
  logic               busy_o;
  logic               deck_empty_o;
  logic [CNT_W-1:0]   cards_dealt_o;

  modport master (
    output deal_req_i, shuffle_i, next_card_i,
    input  req_card_state_o, card_valid_o, card_index_o, card_rank_o,
           card_suit_o, card_value_o, busy_o, deck_empty_o, cards_dealt_o
  );

  modport slave (
    input  deal_req_i, shuffle_i, next_card_i,
    output req_card_state_o, card_valid_o, card_index_o, card_rank_o,
           card_suit_o, card_value_o, busy_o, deck_empty_o, cards_dealt_o
  );
endinterface

// File: rtl/seed_random_4_card_requester.sv
// Requests cards from an external deck counter, rejects invalid (and optionally duplicate) indices,
// decodes the accepted card. Define SEED_RANDOM_4_DUP_FILTER_EN to enable the dealt-card filter.
module seed_random_4_card_requester (
  input logic                           clk_dp_c_i,
  input logic                           rst_dp_c_i,
  seed_random_4_card_requester_if.slave bus
);
  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned OFF_W     = 6;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned VALUE_W   = 5;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic                idx_in_range_c;
  logic                is_dup_c;
  logic                accept_c;
  logic [OFF_W-1:0]    card_off_c;
  logic [SUIT_W-1:0]   suit_c;
  logic [RANK_W-1:0]   rank_c;
  logic [VALUE_W-1:0]  value_c;
  logic [CNT_W-1:0]    dealt_next_c;

  assign idx_in_range_c = (bus.next_card_i != IDX_W'(0)) &&
                          (bus.next_card_i <= IDX_W'(DECK_SIZE));
  assign card_off_c     = OFF_W'(bus.next_card_i - IDX_W'(1));
  assign accept_c       = idx_in_range_c && !is_dup_c;
  assign dealt_next_c   = (bus.cards_dealt_o == CNT_W'(DECK_SIZE)) ?
                          CNT_W'(DECK_SIZE) : CNT_W'(bus.cards_dealt_o + CNT_W'(1));

  // Suit/rank decode of the zero-based card offset, suits in blocks of 13.
  always_comb begin
    suit_c = SUIT_W'(0);
    rank_c = RANK_W'(card_off_c + OFF_W'(1));
    if (card_off_c >= OFF_W'(39)) begin
      suit_c = SUIT_W'(3);
      rank_c = RANK_W'(card_off_c - OFF_W'(38));
    end else if (card_off_c >= OFF_W'(26)) begin
      suit_c = SUIT_W'(2);
      rank_c = RANK_W'(card_off_c - OFF_W'(25));
    end else if (card_off_c >= OFF_W'(13)) begin
      suit_c = SUIT_W'(1);
      rank_c = RANK_W'(card_off_c - OFF_W'(12));
    end
  end

  // Blackjack value: ace counts 11, face cards 10.
  always_comb begin
    value_c = VALUE_W'(10);
    if (rank_c == RANK_W'(1)) begin
      value_c = VALUE_W'(11);
    end else if (rank_c <= RANK_W'(10)) begin
      value_c = VALUE_W'(rank_c);
    end
  end

`ifdef SEED_RANDOM_4_DUP_FILTER_EN
  logic [DECK_SIZE-1:0] dealt_mask;
  logic [DECK_SIZE-1:0] card_bit_c;

  assign card_bit_c = DECK_SIZE'(1) << card_off_c;
  assign is_dup_c   = |(dealt_mask & card_bit_c);

  // Dealt-card mask; a shuffle clears it even on the accepting edge.
  always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
    if (!rst_dp_c_i) begin
      dealt_mask <= '0;
    end else if (bus.shuffle_i) begin
      dealt_mask <= '0;
    end else if ((state == CHECK) && accept_c) begin
      dealt_mask <= dealt_mask | card_bit_c;
    end
  end
`else
  assign is_dup_c = 1'b0;
`endif

  always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
    if (!rst_dp_c_i) begin
      state                <= IDLE;
      bus.req_card_state_o <= 1'b0;
      bus.card_valid_o     <= 1'b0;
      bus.busy_o           <= 1'b0;
      bus.card_index_o     <= '0;
      bus.card_rank_o      <= '0;
      bus.card_suit_o      <= '0;
      bus.card_value_o     <= '0;
      bus.cards_dealt_o    <= '0;
      bus.deck_empty_o     <= 1'b0;
    end else begin
      bus.req_card_state_o <= 1'b0;
      bus.card_valid_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.deal_req_i && !bus.deck_empty_o) begin
            state                <= REQ;
            bus.req_card_state_o <= 1'b1;
            bus.busy_o           <= 1'b1;
          end
        end
        REQ: begin
          state <= CHECK;
        end
        CHECK: begin
          if (accept_c) begin
            state             <= DONE;
            bus.card_valid_o  <= 1'b1;
            bus.card_index_o  <= bus.next_card_i;
            bus.card_rank_o   <= rank_c;
            bus.card_suit_o   <= suit_c;
            bus.card_value_o  <= value_c;
            bus.cards_dealt_o <= dealt_next_c;
            bus.deck_empty_o  <= (dealt_next_c == CNT_W'(DECK_SIZE));
          end else begin
            // Retry: one more advance pulse to the deck counter.
            state                <= REQ;
            bus.req_card_state_o <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.busy_o <= 1'b0;
        end
      endcase
      // Shuffle overrides any same-edge accept on the tracking state.
      if (bus.shuffle_i) begin
        bus.cards_dealt_o <= '0;
        bus.deck_empty_o  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seed_random_4_card_requester.sv
// Bench for seed_random_4_card_requester: deck-counter model plus a card-level reference model.
`timescale 1ns/1ps
module tb_seed_random_4_card_requester;
  localparam int DECK = 52;
`ifdef SEED_RANDOM_4_DUP_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] next_card = 8'd0;

  int checks = 0;
  int fails  = 0;
  int deck_ctr = 0;
  int forced_q[$];
  bit dealt [1:52];
  int m_count = 0;

  seed_random_4_card_requester_if bus();
  seed_random_4_card_requester dut (
    .clk_dp_c_i (clk),
    .rst_dp_c_i (rst),
    .bus        (bus)
  );

  assign bus.next_card_i = next_card;

  always #5 clk = ~clk;

  function automatic int adv(input int c);
    return (c >= DECK) ? 0 : c + 1;
  endfunction

  function automatic int rank_of(input int k);
    return ((k - 1) % 13) + 1;
  endfunction

  function automatic int suit_of(input int k);
    return (k - 1) / 13;
  endfunction

  function automatic int value_of(input int k);
    int r;
    r = rank_of(k);
    if (r == 1) return 11;
    if (r > 10) return 10;
    return r;
  endfunction

  // External deck counter: advances once per high cycle of the request line, wraps 52 -> 0.
  always @(posedge clk) begin
    if (bus.req_card_state_o === 1'b1) begin
      deck_ctr <= adv(deck_ctr);
      if (forced_q.size() > 0) next_card <= 8'(forced_q.pop_front());
      else                     next_card <= 8'(adv(deck_ctr));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 1; i <= DECK; i++) dealt[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic shuffle_pulse();
    bus.shuffle_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.shuffle_i = 1'b0;
    clear_model();
    check("shuffle_count", 32'(bus.cards_dealt_o), 32'(0));
    check("shuffle_empty", 32'(bus.deck_empty_o), 32'(0));
  endtask

  // One deal request; enters and leaves just after a falling edge.
  task automatic deal(input bit shuf_acc);
    int c, v, rej, cyc, reqs, exp_lat;
    bit found;
    int fq[$];
    if (m_count == DECK) begin
      bus.deal_req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); @(negedge clk);
        bus.deal_req_i = 1'b0;
        check("empty_req", 32'(bus.req_card_state_o), 32'(0));
        check("empty_busy", 32'(bus.busy_o), 32'(0));
      end
      return;
    end
    fq = forced_q;
    c = deck_ctr;
    v = 0;
    rej = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      c = adv(c);
      v = (fq.size() > 0) ? fq.pop_front() : c;
      if (v >= 1 && v <= DECK && !(FILTER && dealt[v])) found = 1'b1;
      else rej++;
    end
    check("model_found", 32'(found), 32'(1));
    exp_lat = 3 + 2 * rej;
    bus.deal_req_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.deal_req_i = 1'b0;
    cyc = 1;
    reqs = 0;
    check("busy_in_req", 32'(bus.busy_o), 32'(1));
    while (1) begin
      if (bus.req_card_state_o === 1'b1) reqs++;
      bus.shuffle_i = (shuf_acc && cyc == exp_lat - 1) ? 1'b1 : 1'b0;
      if (bus.card_valid_o === 1'b1 || cyc >= exp_lat + 40) break;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    bus.shuffle_i = 1'b0;
    check("latency", 32'(cyc), 32'(exp_lat));
    check("req_pulses", 32'(reqs), 32'(rej + 1));
    if (shuf_acc) begin
      clear_model();
    end else begin
      dealt[v] = 1'b1;
      if (m_count < DECK) m_count++;
    end
    check("card_index", 32'(bus.card_index_o), 32'(v));
    check("card_rank", 32'(bus.card_rank_o), 32'(rank_of(v)));
    check("card_suit", 32'(bus.card_suit_o), 32'(suit_of(v)));
    check("card_value", 32'(bus.card_value_o), 32'(value_of(v)));
    check("cards_dealt", 32'(bus.cards_dealt_o), 32'(m_count));
    check("deck_empty", 32'(bus.deck_empty_o), 32'(m_count == DECK));
    @(posedge clk); @(negedge clk);
    check("valid_one_cycle", 32'(bus.card_valid_o), 32'(0));
    check("busy_after", 32'(bus.busy_o), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(bus.req_card_state_o), 32'(0));
    check({tag, "_valid"}, 32'(bus.card_valid_o), 32'(0));
    check({tag, "_busy"}, 32'(bus.busy_o), 32'(0));
    check({tag, "_index"}, 32'(bus.card_index_o), 32'(0));
    check({tag, "_rank"}, 32'(bus.card_rank_o), 32'(0));
    check({tag, "_suit"}, 32'(bus.card_suit_o), 32'(0));
    check({tag, "_value"}, 32'(bus.card_value_o), 32'(0));
    check({tag, "_count"}, 32'(bus.cards_dealt_o), 32'(0));
    check({tag, "_empty"}, 32'(bus.deck_empty_o), 32'(0));
  endtask

  initial begin
    rst = 1'b0;
    bus.deal_req_i = 1'b0;
    bus.shuffle_i = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // First deal straight after reset release: counter 0 -> card 1.
    deal(1'b0);
    check("first_index", 32'(bus.card_index_o), 32'(1));
    check("first_rank", 32'(bus.card_rank_o), 32'(1));
    check("first_suit", 32'(bus.card_suit_o), 32'(0));
    check("first_value", 32'(bus.card_value_o), 32'(11));
    check("first_count", 32'(bus.cards_dealt_o), 32'(1));

    for (int n = 2; n <= 13; n++) begin
      deal(1'b0);
      if (n == 10) begin
        check("tenth_rank", 32'(bus.card_rank_o), 32'(10));
        check("tenth_value", 32'(bus.card_value_o), 32'(10));
      end
    end
    check("thirteenth_index", 32'(bus.card_index_o), 32'(13));
    check("thirteenth_rank", 32'(bus.card_rank_o), 32'(13));
    check("thirteenth_suit", 32'(bus.card_suit_o), 32'(0));
    check("thirteenth_value", 32'(bus.card_value_o), 32'(10));

    for (int n = 14; n <= 52; n++) deal(1'b0);
    check("full_empty", 32'(bus.deck_empty_o), 32'(1));
    check("full_count", 32'(bus.cards_dealt_o), 32'(52));
    deal(1'b0);

    // Counter sits at 52: next request wraps to 0, is rejected, then card 1.
    shuffle_pulse();
    deal(1'b0);
    check("wrap_index", 32'(bus.card_index_o), 32'(1));
    check("wrap_count", 32'(bus.cards_dealt_o), 32'(1));

    // Reset in the middle of a transaction.
    bus.deal_req_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.deal_req_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    clear_model();
    deal(1'b0);

    // Forced duplicate: 5 is dealt first, then offered again ahead of 6.
    forced_q.push_back(5);
    deal(1'b0);
    forced_q.push_back(5);
    if (FILTER) forced_q.push_back(6);
    deal(1'b0);
    check("dup_index", 32'(bus.card_index_o), 32'(FILTER ? 6 : 5));

    // Shuffle on the accepting edge wins over the count increment.
    deal(1'b1);
    check("shuf_acc_count", 32'(bus.cards_dealt_o), 32'(0));

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) shuffle_pulse();
      if (m_count < DECK) begin
        for (int k = $urandom_range(0, 3); k > 0; k--) forced_q.push_back(int'($urandom_range(0, 60)));
      end
      deal($urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
